// File: rtl/mem_access.sv
// Memory-access pipeline stage: passes ALU results through, runs a req/ack memory
// transaction for loads and stores. Define MEM_TIMEOUT_EN to add an ack-timeout abort.
module mem_access #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        isld,
    input  logic        isst,
    input  logic        iswb,
    input  logic [3:0]  rd,
    input  logic [31:0] aluresult,
    input  logic [31:0] op2,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_wb,
    output logic [3:0]  out_rd,
    output logic [31:0] out_result,
    output logic        out_err
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0]  state_reg;
    logic        out_valid_reg;
    logic        out_wb_reg;
    logic        out_err_reg;
    logic [3:0]  out_rd_reg;
    logic [31:0] out_result_reg;
    logic        mem_req_reg;
    logic        mem_we_reg;
    logic [31:0] mem_addr_reg;
    logic [31:0] mem_wdata_reg;
    logic        pend_ld_reg;
    logic        pend_wb_reg;
    logic [3:0]  pend_rd_reg;

    logic accept;
    logic is_mem;
    logic ack;
    logic timeout;

    assign in_ready = (state_reg == IDLE) && (!out_valid_reg || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_mem   = isld || isst;
    assign ack      = (state_reg == WAIT) && mem_req_reg && mem_ack;

`ifdef MEM_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] cnt_reg;

    // Abort on the edge where the unacknowledged wait count would reach TIMEOUT_CYCLES.
    assign timeout = (state_reg == WAIT) && !mem_ack && (cnt_reg == TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (accept && is_mem) begin
            cnt_reg <= '0;
        end else if (state_reg == WAIT && !mem_ack) begin
            cnt_reg <= cnt_reg + 16'd1;
        end
    end
`else
    logic [15:0] unused_timeout;
    assign unused_timeout = 16'(TIMEOUT_CYCLES);
    assign timeout        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            out_valid_reg  <= 1'b0;
            out_wb_reg     <= 1'b0;
            out_err_reg    <= 1'b0;
            out_rd_reg     <= '0;
            out_result_reg <= '0;
            mem_req_reg    <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            pend_ld_reg    <= 1'b0;
            pend_wb_reg    <= 1'b0;
            pend_rd_reg    <= '0;
        end else begin
            if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (is_mem) begin
                            // Load wins when both flags are set, so no write is issued.
                            mem_req_reg   <= 1'b1;
                            mem_we_reg    <= isst && !isld;
                            mem_addr_reg  <= aluresult;
                            mem_wdata_reg <= op2;
                            pend_ld_reg   <= isld;
                            pend_wb_reg   <= iswb;
                            pend_rd_reg   <= rd;
                            state_reg     <= WAIT;
                        end else begin
                            out_valid_reg  <= 1'b1;
                            out_result_reg <= aluresult;
                            out_rd_reg     <= rd;
                            out_wb_reg     <= iswb;
                            out_err_reg    <= 1'b0;
                        end
                    end
                end
                default: begin
                    if (ack || timeout) begin
                        mem_req_reg    <= 1'b0;
                        state_reg      <= IDLE;
                        out_valid_reg  <= 1'b1;
                        out_rd_reg     <= pend_rd_reg;
                        out_wb_reg     <= ack ? pend_wb_reg : 1'b0;
                        out_err_reg    <= !ack;
                        // mem_addr_reg still holds the original aluresult.
                        out_result_reg <= (ack && pend_ld_reg) ? mem_rdata : mem_addr_reg;
                    end
                end
            endcase
        end
    end

    assign mem_req    = mem_req_reg;
    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign out_valid  = out_valid_reg;
    assign out_wb     = out_wb_reg;
    assign out_rd     = out_rd_reg;
    assign out_result = out_result_reg;
    assign out_err    = out_err_reg;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed scenarios plus a randomized run against a queue-based
// reference model. Timeout scenario runs only when MEM_TIMEOUT_EN is defined.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        isld;
    logic        isst;
    logic        iswb;
    logic [3:0]  rd;
    logic [31:0] aluresult;
    logic [31:0] op2;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        out_valid;
    logic        out_ready;
    logic        out_wb;
    logic [3:0]  out_rd;
    logic [31:0] out_result;
    logic        out_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        wb;
        logic [3:0]  rd;
        logic [31:0] res;
    } exp_t;

    mem_access #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .isld(isld), .isst(isst), .iswb(iswb), .rd(rd),
        .aluresult(aluresult), .op2(op2),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_wb(out_wb), .out_rd(out_rd), .out_result(out_result), .out_err(out_err)
    );

    always #5 clk = ~clk;

    // Memory contents the bench "returns" for a load from a given address.
    function automatic logic [31:0] rfn(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid = 0; isld = 0; isst = 0; iswb = 0; rd = 0;
        aluresult = 0; op2 = 0; mem_ack = 0; mem_rdata = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        out_ready = 0;
        reset = 1;
        step();
        step();
        reset = 0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%0b exp=0", mem_req); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        total++; if ({out_wb, out_err, out_rd, out_result} !== 38'd0) begin bad++; $display("FAIL reset_out_fields got=%h exp=0", {out_wb, out_err, out_rd, out_result}); end
        total++; if ({mem_we, mem_addr, mem_wdata} !== 65'd0) begin bad++; $display("FAIL reset_mem_fields got=%h exp=0", {mem_we, mem_addr, mem_wdata}); end
        $display("txn reset done");
    endtask

    task automatic test_nonmem();
        out_ready = 1;
        in_valid = 1; aluresult = 32'h55; iswb = 1; rd = 3;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL nonmem_in_ready_pre got=%0b exp=1", in_ready); end
        step();
        in_valid = 0;
        #1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL nonmem_valid got=%0b exp=1", out_valid); end
        total++; if (out_result !== 32'h55) begin bad++; $display("FAIL nonmem_result got=%h exp=%h", out_result, 32'h55); end
        total++; if (out_rd !== 4'd3 || out_wb !== 1'b1) begin bad++; $display("FAIL nonmem_rd_wb got=%0d/%0b exp=3/1", out_rd, out_wb); end
        total++; if (in_ready !== 1'b1 || mem_req !== 1'b0) begin bad++; $display("FAIL nonmem_ready_req got=%0b/%0b exp=1/0", in_ready, mem_req); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL nonmem_drain got=%0b exp=0", out_valid); end
        $display("txn nonmem result=%h rd=%0d", 32'h55, 3);
    endtask

    task automatic test_back_to_back();
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; iswb = i[0]; rd = 4'(i + 8); aluresult = 32'h1000 + 32'(i);
            step();
            total++; if (out_valid !== 1'b1 || out_result !== 32'h1000 + 32'(i) || out_rd !== 4'(i + 8) || out_wb !== i[0]) begin
                bad++; $display("FAIL b2b_%0d got=%0b/%h/%0d/%0b exp=1/%h/%0d/%0b", i, out_valid, out_result, out_rd, out_wb, 32'h1000 + 32'(i), i + 8, i[0]);
            end
            $display("txn b2b idx=%0d result=%h", i, out_result);
        end
        in_valid = 0;
        step();
    endtask

    task automatic test_load();
        out_ready = 1;
        in_valid = 1; isld = 1; iswb = 1; rd = 5; aluresult = 32'h100;
        step();
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            total++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin bad++; $display("FAIL load_req_%0d got=%0b/%0b/%h exp=1/0/100", i, mem_req, mem_we, mem_addr); end
            total++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL load_wait_%0d got=%0b/%0b exp=0/0", i, in_ready, out_valid); end
            if (i == 2) begin mem_ack = 1; mem_rdata = 32'hDEADBEEF; end
            step();
        end
        mem_ack = 0; mem_rdata = 0;
        total++; if (out_valid !== 1'b1 || out_result !== 32'hDEADBEEF) begin bad++; $display("FAIL load_result got=%0b/%h exp=1/deadbeef", out_valid, out_result); end
        total++; if (out_rd !== 4'd5 || out_wb !== 1'b1 || out_err !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL load_fields got=%0d/%0b/%0b/%0b exp=5/1/0/0", out_rd, out_wb, out_err, mem_req); end
        step();
        $display("txn load addr=100 data=deadbeef");
    endtask

    task automatic test_store();
        out_ready = 1;
        in_valid = 1; isst = 1; iswb = 0; rd = 7; aluresult = 32'h200; op2 = 32'h1234;
        step();
        clear_inputs();
        total++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'h1234 || mem_addr !== 32'h200) begin bad++; $display("FAIL store_req got=%0b/%0b/%h/%h exp=1/1/1234/200", mem_req, mem_we, mem_wdata, mem_addr); end
        mem_ack = 1; mem_rdata = 32'hFFFF_0000;
        step();
        mem_ack = 0;
        total++; if (out_valid !== 1'b1 || out_wb !== 1'b0 || out_result !== 32'h200 || out_rd !== 4'd7) begin bad++; $display("FAIL store_out got=%0b/%0b/%h/%0d exp=1/0/200/7", out_valid, out_wb, out_result, out_rd); end
        step();
        $display("txn store addr=200 data=1234");
        // Both flags set behaves as a load with an unaligned address passed through.
        in_valid = 1; isld = 1; isst = 1; iswb = 1; rd = 1; aluresult = 32'h303; op2 = 32'h9;
        step();
        clear_inputs();
        total++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h303) begin bad++; $display("FAIL ldst_req got=%0b/%0b/%h exp=1/0/303", mem_req, mem_we, mem_addr); end
        mem_ack = 1; mem_rdata = 32'hCAFE_F00D;
        step();
        mem_ack = 0;
        total++; if (out_valid !== 1'b1 || out_result !== 32'hCAFE_F00D) begin bad++; $display("FAIL ldst_result got=%0b/%h exp=1/cafef00d", out_valid, out_result); end
        step();
        $display("txn ldst addr=303");
    endtask

    task automatic test_backpressure();
        logic [31:0] held_res;
        out_ready = 0;
        in_valid = 1; iswb = 1; rd = 9; aluresult = 32'hABC;
        step();
        rd = 2; aluresult = 32'h777; iswb = 0;
        held_res = 32'hABC;
        for (int i = 0; i < 4; i++) begin
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready_%0d got=%0b exp=0", i, in_ready); end
            total++; if (out_valid !== 1'b1 || out_result !== held_res || out_rd !== 4'd9 || out_wb !== 1'b1) begin bad++; $display("FAIL bp_hold_%0d got=%0b/%h/%0d/%0b exp=1/abc/9/1", i, out_valid, out_result, out_rd, out_wb); end
            step();
        end
        out_ready = 1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%0b exp=1", in_ready); end
        step();
        in_valid = 0;
        total++; if (out_valid !== 1'b1 || out_result !== 32'h777 || out_rd !== 4'd2 || out_wb !== 1'b0) begin bad++; $display("FAIL bp_next got=%0b/%h/%0d/%0b exp=1/777/2/0", out_valid, out_result, out_rd, out_wb); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%0b exp=0", out_valid); end
        $display("txn backpressure held=abc next=777");
    endtask

    task automatic test_reset_in_wait();
        out_ready = 1;
        in_valid = 1; isld = 1; iswb = 1; rd = 4; aluresult = 32'h440;
        step();
        clear_inputs();
        step();
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rstwait_req got=%0b exp=1", mem_req); end
        reset = 1;
        step();
        reset = 0;
        total++; if (mem_req !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL rstwait_after got=%0b/%0b/%0b exp=0/0/1", mem_req, out_valid, in_ready); end
        mem_ack = 1; mem_rdata = 32'h1111_2222;
        step();
        mem_ack = 0;
        total++; if (out_valid !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL rstwait_late_ack got=%0b/%0b exp=0/0", out_valid, mem_req); end
        step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstwait_quiet got=%0b exp=0", out_valid); end
        $display("txn reset_in_wait discarded");
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        out_ready = 1;
        in_valid = 1; isld = 1; iswb = 1; rd = 6; aluresult = 32'h660;
        step();
        clear_inputs();
        for (int i = 0; i < 4; i++) begin
            total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL timeout_req_%0d got=%0b exp=1", i, mem_req); end
            step();
        end
        total++; if (mem_req !== 1'b0 || out_valid !== 1'b1 || out_err !== 1'b1) begin bad++; $display("FAIL timeout_abort got=%0b/%0b/%0b exp=0/1/1", mem_req, out_valid, out_err); end
        total++; if (out_wb !== 1'b0 || out_result !== 32'h660 || out_rd !== 4'd6) begin bad++; $display("FAIL timeout_fields got=%0b/%h/%0d exp=0/660/6", out_wb, out_result, out_rd); end
        step();
        $display("txn timeout addr=660");
    endtask
`endif

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        exp_t cur;
        logic busy;
        logic exp_ov;
        logic exp_ir;
        logic [31:0] cur_addr;
        logic [31:0] cur_wdata;
        logic cur_we;
        int waitc;
        int done;
        busy = 0; waitc = 0; done = 0;
        cur_addr = 0; cur_wdata = 0; cur_we = 0;
        cur = '{wb: 1'b0, rd: 4'd0, res: 32'd0};
        clear_inputs();
        reset = 1;
        step();
        reset = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            out_ready = ($urandom % 3) != 0;
            in_valid  = ($urandom % 2) == 1;
            case ($urandom % 5)
                0, 1:    begin isld = 0; isst = 0; end
                2:       begin isld = 1; isst = 0; end
                3:       begin isld = 0; isst = 1; end
                default: begin isld = 1; isst = 1; end
            endcase
            iswb = $urandom % 2; rd = 4'($urandom); aluresult = $urandom; op2 = $urandom;
            total++; if (mem_req !== busy) begin bad++; $display("FAIL rnd_mem_req cyc=%0d got=%0b exp=%0b", cyc, mem_req, busy); end
            if (busy) begin
                total++; if (mem_addr !== cur_addr || mem_we !== cur_we || mem_wdata !== cur_wdata) begin
                    bad++; $display("FAIL rnd_mem_bus cyc=%0d got=%h/%0b/%h exp=%h/%0b/%h", cyc, mem_addr, mem_we, mem_wdata, cur_addr, cur_we, cur_wdata);
                end
                waitc++;
                if (waitc >= 3 || ($urandom % 2) == 1) begin mem_ack = 1; mem_rdata = rfn(cur_addr); end
                else begin mem_ack = 0; mem_rdata = $urandom; end
            end else begin
                mem_ack = ($urandom % 4) == 0; mem_rdata = $urandom;
            end
            #1;
            exp_ov = (q.size() > 0) && !busy;
            exp_ir = !busy && (!exp_ov || out_ready);
            total++; if (out_valid !== exp_ov) begin bad++; $display("FAIL rnd_out_valid cyc=%0d got=%0b exp=%0b", cyc, out_valid, exp_ov); end
            total++; if (in_ready !== exp_ir) begin bad++; $display("FAIL rnd_in_ready cyc=%0d got=%0b exp=%0b", cyc, in_ready, exp_ir); end
            if (exp_ov && out_ready) begin
                e = q.pop_front();
                total++; if (out_result !== e.res || out_rd !== e.rd || out_wb !== e.wb || out_err !== 1'b0) begin
                    bad++; $display("FAIL rnd_bundle cyc=%0d got=%h/%0d/%0b/%0b exp=%h/%0d/%0b/0", cyc, out_result, out_rd, out_wb, out_err, e.res, e.rd, e.wb);
                end
                done++;
                $display("txn rnd %0d result=%h rd=%0d wb=%0b", done, e.res, e.rd, e.wb);
            end
            if (busy && mem_ack) begin
                busy = 0;
                q.push_back(cur);
            end else if (in_valid && exp_ir) begin
                if (isld || isst) begin
                    busy = 1; waitc = 0;
                    cur_addr = aluresult; cur_wdata = op2; cur_we = isst && !isld;
                    cur = '{wb: iswb, rd: rd, res: isld ? rfn(aluresult) : aluresult};
                end else begin
                    q.push_back('{wb: iswb, rd: rd, res: aluresult});
                end
            end
        end
        @(negedge clk);
        clear_inputs();
        total++; if (done < 50) begin bad++; $display("FAIL rnd_throughput got=%0d exp>=50", done); end
    endtask

    initial begin
        reset = 1;
        out_ready = 0;
        clear_inputs();
        test_reset();
        test_nonmem();
        test_back_to_back();
        test_load();
        test_store();
        test_backpressure();
        test_reset_in_wait();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access stage directly downstream of the execute stage in the 32-bit RISC pipeline.
- Takes the ALU result (load/store address or plain result) and store data from execute.
- Performs a multi-cycle request/acknowledge transaction with data memory for ld/st.
- Delivers a registered result, destination register and write-enable to writeback, with valid/ready flow control.

Parameters:
- TIMEOUT_CYCLES, 255, max wait cycles for mem_ack before abort (used only with MEM_TIMEOUT_EN); legal range 1..65535.

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  execute presents a valid instruction
- in_ready  output  1  stage can accept an instruction this cycle
- isld  input  1  instruction is a load
- isst  input  1  instruction is a store
- iswb  input  1  instruction writes a register
- rd  input  4  destination register index
- aluresult  input  32  ALU result / effective address
- op2  input  32  store data
- mem_req  output  1  memory request, held until acknowledged
- mem_we  output  1  1 = write, 0 = read
- mem_addr  output  32  memory address
- mem_wdata  output  32  store data to memory
- mem_rdata  input  32  load data, valid when mem_ack = 1
- mem_ack  input  1  memory completes the request this cycle
- out_valid  output  1  writeback bundle valid
- out_ready  input  1  writeback consumes the bundle
- out_wb  output  1  register write enable to writeback
- out_rd  output  4  destination register
- out_result  output  32  load data for loads, otherwise aluresult
- out_err  output  1  transaction aborted

Behaviour:
- Clocking and reset: one clock `clk`; `reset` is synchronous and active-high.
- On reset, all outputs are 0 (in_ready reads 1 once out_valid = 0) and the FSM goes to IDLE.
- Reset mid-transaction: mem_req drops at that edge and the in-flight instruction is discarded with no output.
- FSM states: IDLE, WAIT.
- in_ready = (state == IDLE) && (!out_valid || out_ready).
- Accept = in_valid && in_ready, sampled at rising edge T.
- Non-memory instruction (isld = isst = 0):
  - At T: out_valid = 1, out_result = aluresult, out_rd = rd, out_wb = iswb.
  - Latency is 1 cycle; back-to-back accepts give 1 instruction per cycle.
- Memory instruction:
  - At T: latch mem_addr = aluresult, mem_wdata = op2, mem_we = isst && !isld.
  - At T: assert mem_req and go to WAIT.
  - isld && isst together is executed as a load; no write occurs.
- WAIT:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - On the first edge with mem_ack = 1: mem_req = 0, state = IDLE, out_valid = 1, out_rd = rd.
  - On that edge, out_wb = iswb; out_result = mem_rdata for a load, aluresult for a store.
  - With ack k cycles after the request rises (k ≥ 1), out_valid rises at T + k.
- mem_ack while in IDLE, or while mem_req = 0, is ignored.
- Output hold: out_* are held stable while out_valid && !out_ready.
- out_valid clears on a handshake edge unless a new instruction is accepted on the same edge. If one is accepted, the output updates in place.
- mem_addr is passed unmodified, including the low 2 bits; no alignment check.
- out_err = 0 in all non-timeout cases.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle without mem_ack.
  - When the count reaches TIMEOUT_CYCLES with no ack: mem_req = 0, state = IDLE, out_valid = 1, out_err = 1, out_wb = 0, out_result = aluresult.
  - An ack on the same edge as the timeout wins; the result is a normal completion.
- Undefined:
  - No counter is built; WAIT persists until mem_ack.
  - out_err is tied to 0.

Test Plan:
- Non-memory: aluresult = 0x0000_0055, iswb = 1, rd = 3, out_ready = 1 -> next edge out_valid = 1, out_result = 0x55, out_rd = 3, out_wb = 1; in_ready stays 1.
- Load: aluresult = 0x100, isld = 1, rd = 5; mem_ack after 3 cycles with mem_rdata = 0xDEADBEEF -> mem_req = 1, mem_we = 0, mem_addr = 0x100 for 3 cycles; then out_result = 0xDEADBEEF, out_rd = 5; in_ready = 0 during WAIT.
- Store: aluresult = 0x200, op2 = 0x1234, isst = 1, iswb = 0; ack after 1 cycle -> mem_we = 1, mem_wdata = 0x1234; out_wb = 0, out_result = 0x200.
- Backpressure: out_ready = 0 for 4 cycles after a valid output -> in_ready = 0 and out_* stable; the new instruction is accepted on the edge out_ready returns to 1.
- Reset during WAIT (load pending, no ack) -> next edge mem_req = 0, out_valid = 0, state IDLE; a late mem_ack is ignored.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES = 4, load never acked -> mem_req high 4 cycles then drops; out_valid = 1, out_err = 1, out_wb = 0.
